// File: rtl/fnd_scan_if.sv
// fnd_scan_if: signal bundle between the display scanner and its environment.
//   in_val   : 4-bit count value from the counter stage (asynchronous to clk)
//   seg      : segment drive {g,f,e,d,c,b,a}
//   dp       : decimal point drive
//   com      : one-hot digit select
//   wrap_cnt : BCD wrap count {tens, ones}
//   change   : one-cycle pulse on each accepted value change
// The slave modport is the scanner; the master modport is whatever feeds it.
interface fnd_scan_if;
  logic [3:0] in_val;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] com;
  logic [7:0] wrap_cnt;
  logic       change;

  modport master (
    output in_val,
    input  seg,
    input  dp,
    input  com,
    input  wrap_cnt,
    input  change
  );

  modport slave (
    input  in_val,
    output seg,
    output dp,
    output com,
    output wrap_cnt,
    output change
  );
endinterface

// File: rtl/fnd_scan.sv
// fnd_scan: display stage for the decimal counter.
// Synchronises and filters the 4-bit count, counts wrap-arounds to zero in BCD and drives a
// 4-digit multiplexed 7-segment display:
//   digit 0 : count ones
//   digit 1 : count tens (blank when zero)
//   digit 2 : wrap ones, decimal point lit
//   digit 3 : wrap tens (always shown)
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : fnd_scan_if slave (in_val in; seg, dp, com, wrap_cnt, change out)
// Parameters:
//   SCAN_DIV   : clk cycles per digit slot (4..65535)
//   BLANK      : cycles at the start of each slot with all commons inactive (< SCAN_DIV)
//   COM_ACTIVE : active level of com
//   SEG_ACTIVE : active level of seg and dp
module fnd_scan #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK      = 4,
  parameter bit          COM_ACTIVE = 1'b0,
  parameter bit          SEG_ACTIVE = 1'b0
) (
  input logic       clk,
  input logic       rst,
  fnd_scan_if.slave bus
);

  localparam logic [15:0] DivLast  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BlankEnd = 16'(BLANK);
  localparam logic [3:0]  ComOff   = {4{~COM_ACTIVE}};
  localparam logic [6:0]  SegOff   = {7{~SEG_ACTIVE}};

  // Active-high segment pattern for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // State
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [3:0]  s2d;
  logic [3:0]  cur;
  logic [3:0]  wrap_ones;
  logic [3:0]  wrap_tens;
  logic [15:0] div;
  logic [1:0]  idx;
  logic        change_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  com_q;

  // Next-state / decode
  logic       accept;
  logic       wrap_hit;
  logic [3:0] wrap_ones_d;
  logic [3:0] wrap_tens_d;
  logic [3:0] cur_tens;
  logic [3:0] cur_ones;
  logic [3:0] digit_val;
  logic       digit_blank;
  logic       digit_dp;
  logic [6:0] seg_hi;
  logic [3:0] com_sel;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] com_d;

  always_comb begin
    // s2 must have been stable for two consecutive samples, so a one-cycle value never lands.
    accept   = (s2 == s2d) && (s2 != cur);
    wrap_hit = accept && (cur != 4'd0) && (s2 == 4'd0);

    wrap_ones_d = wrap_ones;
    wrap_tens_d = wrap_tens;
    if (wrap_hit) begin
      if (wrap_ones == 4'd9) begin
        wrap_ones_d = 4'd0;
        wrap_tens_d = (wrap_tens == 4'd9) ? 4'd0 : wrap_tens + 4'd1;
      end else begin
        wrap_ones_d = wrap_ones + 4'd1;
      end
    end

    if (cur >= 4'd10) begin
      cur_tens = 4'd1;
      cur_ones = cur - 4'd10;
    end else begin
      cur_tens = 4'd0;
      cur_ones = cur;
    end

    digit_val   = 4'd0;
    digit_blank = 1'b0;
    digit_dp    = 1'b0;
    unique case (idx)
      2'd0: digit_val = cur_ones;
      2'd1: begin
        digit_val   = cur_tens;
        digit_blank = (cur_tens == 4'd0);
      end
      2'd2: begin
        digit_val = wrap_ones;
        digit_dp  = 1'b1;
      end
      2'd3: digit_val = wrap_tens;
      default: digit_val = 4'd0;
    endcase

    seg_hi = digit_blank ? 7'h00 : seg_decode(digit_val);
    seg_d  = SEG_ACTIVE ? seg_hi : ~seg_hi;
    dp_d   = SEG_ACTIVE ? digit_dp : ~digit_dp;

    // Commons stay off for the first BLANK cycles of a slot so the previous digit's segments
    // never bleed into the next digit.
    com_sel = 4'b0001 << idx;
    if (div < BlankEnd) begin
      com_d = ComOff;
    end else begin
      com_d = COM_ACTIVE ? com_sel : ~com_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= 4'd0;
      s2        <= 4'd0;
      s2d       <= 4'd0;
      cur       <= 4'd0;
      wrap_ones <= 4'd0;
      wrap_tens <= 4'd0;
      div       <= 16'd0;
      idx       <= 2'd0;
      change_q  <= 1'b0;
      seg_q     <= SegOff;
      dp_q      <= ~SEG_ACTIVE;
      com_q     <= ComOff;
    end else begin
      s1  <= bus.in_val;
      s2  <= s1;
      s2d <= s2;
      if (accept) begin
        cur <= s2;
      end
      change_q  <= accept;
      wrap_ones <= wrap_ones_d;
      wrap_tens <= wrap_tens_d;

      if (div == DivLast) begin
        div <= 16'd0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 16'd1;
      end

      // Outputs are registered from pre-edge state: one cycle behind idx/div/cur.
      seg_q <= seg_d;
      dp_q  <= dp_d;
      com_q <= com_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.com      = com_q;
  assign bus.wrap_cnt = {wrap_tens, wrap_ones};
  assign bus.change   = change_q;

endmodule

// File: tb/tb_fnd_scan.sv
// tb_fnd_scan: self-checking bench for fnd_scan.
// u_dflt uses default parameters for the reset checks; u_fast (SCAN_DIV=8, BLANK=2) covers
// scanning, value acceptance, glitch rejection, wrap counting and reset mid-scan.
// Expected wrap counts are queued when a value change is driven and popped on each change pulse.
module tb_fnd_scan;

  localparam logic [6:0] Dec [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk;
  logic rst_d;
  logic rst_f;

  fnd_scan_if bus_d ();
  fnd_scan_if bus_f ();

  fnd_scan u_dflt (
    .clk (clk),
    .rst (rst_d),
    .bus (bus_d)
  );

  fnd_scan #(
    .SCAN_DIV (8),
    .BLANK    (2)
  ) u_fast (
    .clk (clk),
    .rst (rst_f),
    .bus (bus_f)
  );

  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          model_cur;
  int          model_wrap;
  logic [7:0]  exp_q [$];
  logic [7:0]  sb_exp;
  logic        change_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Expected segment drive (active-low) for a digit position from the bench's own model.
  function automatic logic [6:0] exp_seg(input int ix);
    int         t;
    int         o;
    logic [6:0] hi;
    t  = (model_cur >= 10) ? 1 : 0;
    o  = model_cur - 10 * t;
    hi = 7'h00;
    case (ix)
      0:       hi = Dec[o];
      1:       hi = (t == 0) ? 7'h00 : Dec[t];
      2:       hi = Dec[model_wrap % 10];
      default: hi = Dec[model_wrap / 10];
    endcase
    return ~hi;
  endfunction

  // Scoreboard consumer: every change pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus_f.change) begin
      check("change_width", 32'(change_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("change_unexpected", 32'(bus_f.change), 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("change_wrap", 32'(bus_f.wrap_cnt), 32'(sb_exp));
      end
    end
    change_prev <= bus_f.change;
  end

  task automatic set_val(input int v);
    if (v != model_cur) begin
      if (model_cur != 0 && v == 0) model_wrap = (model_wrap + 1) % 100;
      model_cur = v;
      exp_q.push_back(to_bcd(model_wrap));
    end
    @(negedge clk);
    bus_f.in_val = 4'(v);
    repeat (6) @(negedge clk);
  endtask

  task automatic show_check(input int ix, input string tag);
    logic [3:0] want;
    int         n;
    want = ~(4'b0001 << ix);
    n    = 0;
    @(negedge clk);
    while (bus_f.com !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus_f.com !== want) begin
      check({tag, "_timeout"}, 32'(bus_f.com), 32'(want));
    end else begin
      check({tag, "_seg"}, 32'(bus_f.seg), 32'(exp_seg(ix)));
      check({tag, "_dp"}, 32'(bus_f.dp), (ix == 2) ? 32'd0 : 32'd1);
    end
  endtask

  // Per-cycle scan check starting at the first edge after reset release.
  task automatic scan_check(input int cycles, input string tag);
    int         d;
    int         ix;
    logic [3:0] want;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      d    = (k - 1) % 8;
      ix   = ((k - 1) / 8) % 4;
      want = (d < 2) ? 4'hF : ~(4'b0001 << ix);
      check({tag, "_com"}, 32'(bus_f.com), 32'(want));
      if (d >= 2) begin
        check({tag, "_seg"}, 32'(bus_f.seg), 32'(exp_seg(ix)));
        check({tag, "_dp"}, 32'(bus_f.dp), (ix == 2) ? 32'd0 : 32'd1);
      end
    end
  endtask

  initial begin
    int n;
    clk          = 1'b0;
    rst_d        = 1'b0;
    rst_f        = 1'b0;
    n_cmp        = 0;
    n_err        = 0;
    model_cur    = 0;
    model_wrap   = 0;
    change_prev  = 1'b0;
    bus_d.in_val = 4'd5;
    bus_f.in_val = 4'd0;

    // Reset state, default parameters.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_com", 32'(bus_d.com), 32'hF);
    check("rst_seg", 32'(bus_d.seg), 32'h7F);
    check("rst_dp", 32'(bus_d.dp), 32'd1);
    check("rst_wrap", 32'(bus_d.wrap_cnt), 32'h00);
    check("rst_change", 32'(bus_d.change), 32'd0);
    check("rst_f_com", 32'(bus_f.com), 32'hF);
    check("rst_f_seg", 32'(bus_f.seg), 32'h7F);
    rst_d = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("rel_com", 32'(bus_d.com), (k <= 4) ? 32'hF : 32'hE);
    end

    // Scan order and blank windows, two full periods.
    rst_f = 1'b1;
    scan_check(64, "scan");

    // Accept 0 -> 7: change high only in the cycle after E3.
    model_cur = 7;
    exp_q.push_back(to_bcd(model_wrap));
    bus_f.in_val = 4'd7;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("acc_pulse", 32'(bus_f.change), (k == 3) ? 32'd1 : 32'd0);
    end
    show_check(0, "acc_d0");
    show_check(1, "acc_d1");

    // Two-digit value.
    set_val(12);
    show_check(0, "v12_d0");
    show_check(1, "v12_d1");
    show_check(2, "v12_d2");
    show_check(3, "v12_d3");

    // Glitch reject: 9 for exactly one cycle.
    set_val(3);
    @(negedge clk);
    bus_f.in_val = 4'd9;
    @(negedge clk);
    bus_f.in_val = 4'd3;
    repeat (8) @(negedge clk);
    check("glitch_wrap", 32'(bus_f.wrap_cnt), 32'(to_bcd(model_wrap)));
    show_check(0, "glitch_d0");

    // 5 -> 7 -> 0 adds exactly one wrap.
    set_val(5);
    set_val(7);
    set_val(0);
    check("wrap_one", 32'(bus_f.wrap_cnt), 32'h01);

    for (int i = 0; i < 98; i++) begin
      set_val(10);
      set_val(0);
    end
    check("wrap_99", 32'(bus_f.wrap_cnt), 32'h99);
    show_check(2, "w99_d2");
    show_check(3, "w99_d3");
    set_val(10);
    set_val(0);
    check("wrap_roll", 32'(bus_f.wrap_cnt), 32'h00);
    set_val(10);
    set_val(0);
    check("wrap_after", 32'(bus_f.wrap_cnt), 32'h01);

    // Reset mid-scan during digit 2.
    n = 0;
    while (bus_f.com !== 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_d2", 32'(bus_f.com), 32'hB);
    rst_f = 1'b0;
    @(negedge clk);
    rst_f      = 1'b1;
    model_cur  = 0;
    model_wrap = 0;
    check("mid_rst_com", 32'(bus_f.com), 32'hF);
    check("mid_rst_wrap", 32'(bus_f.wrap_cnt), 32'h00);
    check("mid_rst_change", 32'(bus_f.change), 32'd0);
    scan_check(12, "mid_scan");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
